// File: rtl/digit_seq_pkg.sv
// -----------------------------------------------------------------------------
// digit_seq_pkg
// Shared constants and types for the six-digit HEX display sequencer.
//   STATE_W   : width of the FSM state encoding (also the debug LED bus)
//   WIDTH_DEF : default bits per displayed digit (one switch nibble)
//   DIGITS    : number of display digits
//   state_t   : FSM encoding; codes 5..7 are unused and recover to IDLE
// -----------------------------------------------------------------------------
package digit_seq_pkg;

    localparam int STATE_W   = 3;
    localparam int WIDTH_DEF = 4;
    localparam int DIGITS    = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_READ   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

endpackage

// File: rtl/key_sync_edge.sv
// -----------------------------------------------------------------------------
// key_sync_edge
// Synchronizes the asynchronous active-low load pushbutton and turns a fresh
// press into a single-cycle pulse while the controller is waiting.
//   clock       : system clock
//   reset       : synchronous active-low reset
//   i_key_n     : raw pushbutton, active-low, asynchronous to clock
//   i_enable    : high while the controller sits in WAIT
//   o_key_level : synchronized key level (active-low, 1 = released)
//   o_press     : one-cycle pulse for a press seen after a release
// -----------------------------------------------------------------------------
module key_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key_n,
    input  logic i_enable,
    output logic o_key_level,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_armed;
    logic                   w_released;

    // Arm only once every stage reads "released". The reset preset of the
    // chain is all ones, so a key held through reset would otherwise look like
    // a release for the first cycles and produce a spurious load.
    assign w_released  = &r_sync;
    assign o_key_level = r_sync[SYNC_STAGES-1];
    assign o_press     = i_enable && r_armed && !o_key_level;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync  <= '1;
            r_armed <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_key_n);
            if (o_press) begin
                r_armed <= 1'b0;
            end else if (i_enable && w_released) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_shift_sequencer.sv
// -----------------------------------------------------------------------------
// digit_shift_sequencer
// Load-key controller plus six-digit bank for the HEX display path. Each press
// shifts the switch nibble in at digit 0 (digit 5 falls off); with scroll mode
// on, the digits rotate once per tick while the controller is idle in WAIT.
//   clock      : system clock, rising edge
//   reset      : synchronous active-low reset
//   data       : digit value from the switches
//   load_key   : pushbutton, active-low, asynchronous
//   scroll_en  : 1 = rotate digits on each tick while in WAIT
//   out0..out5 : displayed digit nibbles, out0 = newest / rightmost
//   busy       : 1 whenever the FSM is not in WAIT
//   state_o    : current state encoding for debug LEDs
// -----------------------------------------------------------------------------
module digit_shift_sequencer
    import digit_seq_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data,
    input  logic               load_key,
    input  logic               scroll_en,
    output logic [WIDTH-1:0]   out0,
    output logic [WIDTH-1:0]   out1,
    output logic [WIDTH-1:0]   out2,
    output logic [WIDTH-1:0]   out3,
    output logic [WIDTH-1:0]   out4,
    output logic [WIDTH-1:0]   out5,
    output logic               busy,
    output logic [STATE_W-1:0] state_o
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_digit [DIGITS];
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic             w_key_level;
    logic             w_press;
    logic             w_in_wait;
    logic             w_rotate;

    assign w_in_wait = (r_state == ST_WAIT);
    assign w_tick    = (r_tick_cnt == TICK_LAST);
    // A press on a tick cycle wins; that tick is simply dropped.
    assign w_rotate  = w_in_wait && scroll_en && w_tick && !w_press;

    key_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_key (
        .clock      (clock),
        .reset      (reset),
        .i_key_n    (load_key),
        .i_enable   (w_in_wait),
        .o_key_level(w_key_level),
        .o_press    (w_press)
    );

    // Free-running pace counter; runs in every state so scroll_en changes
    // never restart the period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; any path leaving w_next_state unassigned infers a latch.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next_state = ST_WAIT;
            ST_WAIT:   w_next_state = w_press ? ST_READ : ST_WAIT;
            ST_READ:   w_next_state = ST_SHIFT;
            ST_SHIFT:  w_next_state = ST_OUTPUT;
            // Stay until the key is released so one press gives one shift.
            ST_OUTPUT: w_next_state = w_key_level ? ST_WAIT : ST_OUTPUT;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: the digit bank is cleared on reset because the display must show
    // zeros after reset; plain storage arrays without that need stay unreset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hold <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                r_digit[i] <= '0;
            end
        end else begin
            if (r_state == ST_READ) begin
                r_hold <= data;
            end
            if (r_state == ST_SHIFT) begin
                r_digit[0] <= r_hold;
                for (int i = 1; i < DIGITS; i++) begin
                    r_digit[i] <= r_digit[i-1];
                end
            end else if (w_rotate) begin
                r_digit[0] <= r_digit[DIGITS-1];
                for (int i = 1; i < DIGITS; i++) begin
                    r_digit[i] <= r_digit[i-1];
                end
            end
        end
    end

    assign out0    = r_digit[0];
    assign out1    = r_digit[1];
    assign out2    = r_digit[2];
    assign out3    = r_digit[3];
    assign out4    = r_digit[4];
    assign out5    = r_digit[5];
    assign busy    = !w_in_wait;
    assign state_o = r_state;

endmodule

// File: tb/tb_digit_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_digit_shift_sequencer
// Self-checking bench: a reference digit model drives a scoreboard queue of
// expected digit banks; each press pushes its expected result and the bench
// pops it when the shift becomes visible.
// -----------------------------------------------------------------------------
module tb_digit_shift_sequencer;

    localparam int TDIV = 8;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] data      = 4'h0;
    logic       load_key  = 1'b1;
    logic       scroll_en = 1'b0;
    logic [3:0] out0, out1, out2, out3, out4, out5;
    logic       busy;
    logic [2:0] state_o;

    int          total = 0;
    int          bad   = 0;
    int          ecnt  = 0;
    logic [3:0]  m_dig [6];
    logic [23:0] sb_q [$];

    digit_shift_sequencer #(
        .WIDTH      (4),
        .TICK_DIV   (TDIV),
        .SYNC_STAGES(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .load_key (load_key),
        .scroll_en(scroll_en),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4),
        .out5     (out5),
        .busy     (busy),
        .state_o  (state_o)
    );

    always #5 clock = ~clock;

    // Edges since reset release; the DUT pace counter ticks into a rotation
    // on every edge where this count is a multiple of TDIV.
    always @(posedge clock) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_pack();
        return {out5, out4, out3, out2, out1, out0};
    endfunction

    function automatic logic [23:0] model_pack();
        return {m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 6; n++) m_dig[n] = 4'h0;
    endtask

    task automatic model_shift(input logic [3:0] d);
        for (int n = 5; n > 0; n--) m_dig[n] = m_dig[n-1];
        m_dig[0] = d;
    endtask

    task automatic model_rotate();
        logic [3:0] top;
        top = m_dig[5];
        for (int n = 5; n > 0; n--) m_dig[n] = m_dig[n-1];
        m_dig[0] = top;
    endtask

    // One idle cycle in WAIT; applies any scroll rotation to the model.
    task automatic idle_cycle();
        @(posedge clock);
        @(negedge clock);
        if (scroll_en && (ecnt % TDIV == 0)) model_rotate();
        check("idle_dig", dut_pack(), model_pack());
    endtask

    // Pin low for 'hold' cycles starting before edge 1. Expected timeline:
    // READ after edge 3, data captured at edge 4, digits shift at edge 5,
    // back in WAIT at edge max(hold+3, 6).
    task automatic press_key(input logic [3:0] d, input int hold, input bit vary);
        logic [23:0] before_d;
        int          fall;
        before_d = model_pack();
        fall     = (hold + 3 > 6) ? hold + 3 : 6;
        for (int i = 1; i <= fall; i++) begin
            load_key = (i <= hold) ? 1'b0 : 1'b1;
            data     = vary ? 4'($urandom_range(0, 15)) : d;
            if (i == 4) begin
                model_shift(data);
                sb_q.push_back(model_pack());
            end
            @(posedge clock);
            @(negedge clock);
            if (i == 2) check("busy_pre", {23'd0, busy}, 24'd0);
            if (i == 3) check("busy_read", {23'd0, busy}, 24'd1);
            if (i == 4) check("dig_early", dut_pack(), before_d);
            if (i == 5) check("dig_shift", dut_pack(), sb_q.pop_front());
            if (i == fall - 1) check("busy_hold", {23'd0, busy}, 24'd1);
            if (i == fall) begin
                check("busy_end", {23'd0, busy}, 24'd0);
                check("dig_once", dut_pack(), model_pack());
            end
        end
        load_key = 1'b1;
    endtask

    initial begin
        model_clear();

        // Reset and idle
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_state", {21'd0, state_o}, 24'd0);
        check("rst_busy", {23'd0, busy}, 24'd1);
        check("rst_dig", dut_pack(), 24'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("idle_to_wait", {21'd0, state_o}, 24'd1);
        check("wait_busy", {23'd0, busy}, 24'd0);
        for (int n = 0; n < 9; n++) begin
            idle_cycle();
            check("wait_state", {21'd0, state_o}, 24'd1);
        end

        // Three loads
        press_key(4'h3, 3, 1'b0);
        idle_cycle();
        press_key(4'h7, 4, 1'b0);
        idle_cycle();
        press_key(4'hA, 2, 1'b0);
        idle_cycle();
        check("three_loads", dut_pack(), 24'h00037A);

        // Seven loads, oldest discarded
        for (int v = 1; v <= 7; v++) begin
            press_key(4'(v), 2, 1'b0);
            idle_cycle();
        end
        check("seven_loads", dut_pack(), 24'h234567);

        // Long hold with changing switches: one shift only
        press_key(4'h0, 1000, 1'b1);
        for (int n = 0; n < 4; n++) idle_cycle();

        // Scroll: load 1..6, then rotate on ticks
        for (int v = 1; v <= 6; v++) begin
            press_key(4'(v), 2, 1'b0);
            idle_cycle();
        end
        check("load_16", dut_pack(), 24'h123456);
        scroll_en = 1'b1;
        for (int n = 0; n < 2 * TDIV; n++) begin
            idle_cycle();
            if (ecnt % TDIV == 0) break;
        end
        check("rot_out0", {20'd0, out0}, 24'd1);
        check("rot_out1", {20'd0, out1}, 24'd6);
        for (int n = 0; n < 2 * TDIV; n++) idle_cycle();
        // Align so the WAIT->READ edge coincides with a rotation edge
        for (int n = 0; n < 2 * TDIV && (ecnt % TDIV) != TDIV - 3; n++) idle_cycle();
        press_key(4'h9, 2, 1'b0);
        for (int n = 0; n < 2 * TDIV + 4; n++) idle_cycle();
        scroll_en = 1'b0;
        idle_cycle();

        // Reset in SHIFT with the key held through reset
        load_key = 1'b0;
        data     = 4'hC;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("in_shift", {21'd0, state_o}, 24'd3);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        model_clear();
        check("rst_mid_dig", dut_pack(), 24'd0);
        check("rst_mid_st", {21'd0, state_o}, 24'd0);
        idle_cycle();
        reset = 1'b1;
        for (int n = 0; n < 12; n++) idle_cycle();
        check("held_no_load", {21'd0, state_o}, 24'd1);
        load_key = 1'b1;
        for (int n = 0; n < 3; n++) idle_cycle();
        press_key(4'h5, 3, 1'b0);
        idle_cycle();
        check("fresh_load", dut_pack(), 24'h000005);

        check("sb_empty", 24'(sb_q.size()), 24'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_shift_sequencer.md
Name: digit_shift_sequencer

Overview:
Controller plus digit bank for the six-digit HEX display path. Each load-key press captures the 4-bit switch value and shifts it in at digit 0. Existing digits move toward digit 5, and the old digit 5 is discarded. An optional scroll mode rotates the displayed digits at a fixed pace while idle. Outputs drive the existing hex-decoder instances directly, one nibble per HEX digit.

Parameters:
DIGITS, 6, number of display digits (out0..out5); fixed at 6 for port list, used for internal loops
WIDTH, 4, bits per digit / data switch width
TICK_DIV, 50000000, scroll pace divider in clock cycles (1 s at 50 MHz); minimum 2
SYNC_STAGES, 2, synchronizer depth for load_key

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset (KEY0); sampled on rising edge of clock
data  input  4  digit value from switches SW3..SW0; all 16 codes legal
load_key  input  1  pushbutton KEY1, active-low, asynchronous to clock
scroll_en  input  1  SW9; 1 = rotate digits on each tick while in WAIT
out0..out5  output  4 each  displayed digit nibbles, out0 = newest / rightmost
busy  output  1  1 whenever state != WAIT
state_o  output  3  current state encoding, for debug LEDs

Behaviour:
- Reset:
  - reset=0 at a rising edge forces state=IDLE, out0..out5=0, hold=0, tick counter=0, synchronizer flops=1 (key released), armed=0.
  - Reset has priority over every other event, including mid-operation in READ or SHIFT.
- State encoding: IDLE=0, WAIT=1, READ=2, SHIFT=3, OUTPUT=4. Codes 5-7 are illegal; if reached, go to IDLE next cycle without changing digits.
- IDLE: exactly one cycle, then WAIT.
- WAIT (busy=0):
  - armed is set whenever synchronized key=1.
  - press = armed && synchronized key=0 → next state READ, and armed is cleared.
  - A key held down through reset produces no load until it is released and pressed again.
- READ: hold <= data; next state SHIFT. The data sampled is the switch value at this edge.
- SHIFT: out5<=out4, out4<=out3, out3<=out2, out2<=out1, out1<=out0, out0<=hold; next state OUTPUT.
- OUTPUT: remains in OUTPUT while synchronized key=0; goes to WAIT on the first cycle key=1. This gives exactly one shift per press regardless of hold length.
- Latency: pin low before edge k → synchronizer output low after edge k+1 → WAIT→READ at edge k+2 → data captured at edge k+3 → digits updated at edge k+4.
- Tick counter:
  - Free-running 0..TICK_DIV-1 in all states; tick=1 for one cycle at the terminal count, then wraps to 0.
  - Width is ceil(log2(TICK_DIV)).
- Scroll: in WAIT with scroll_en=1 and tick=1, rotate left: out0<=out5, outN<=out(N-1); the state stays WAIT. Rotation never happens outside WAIT.
- Simultaneous press and tick in WAIT: the press wins, no rotation occurs that cycle, and the tick is lost (not deferred).
- scroll_en toggling mid-tick-period does not reset the counter.
- No arithmetic on digit values; nibbles pass unmodified.

Decomposition:
- Shared package digit_seq_pkg holds:
  - state encodings IDLE..OUTPUT and the 3-bit state width
  - the WIDTH default
  - the DIGITS constant
- Sub-module key_sync_edge: SYNC_STAGES-deep synchronizer plus the armed/press logic. Outputs are key_level (synchronized, active-low) and press (1-cycle pulse). It takes clock, reset, and the enable from WAIT.
- Digit bank and FSM stay in the top module.

Test Plan:
- Reset then idle 10 cycles → out0..out5=0, state_o goes 0 then 1, busy=0 from the second cycle onward.
- Press and release sequence with data=3, then 7, then A → out0=A, out1=7, out2=3, rest 0; digits change exactly 4 cycles after each pin fall.
- Seven presses with data=1..7 → out5..out0 = 2,3,4,5,6,7 (value 1 discarded).
- Key held low for 1000 cycles with data changing every cycle → exactly one shift, busy=1 until 2-3 cycles after release.
- TICK_DIV=8, digits 1..6 loaded, scroll_en=1 → each tick rotates: after one tick out0=1 (old out5), out1=6; a press on a tick cycle shifts instead of rotating.
- Key held through reset, and reset asserted in SHIFT → no load on reset release, all digits 0; load occurs only after release and a fresh press.
